// File: rtl/vend_fsm_param.sv
// Parameterised vending machine controller: accumulates coins, vends at PRICE, refunds on cancel.
// Optional idle-collect timeout refund enabled by defining VEND_TIMEOUT_EN.
module vend_fsm_param #(
   parameter int unsigned PRICE       = 3,
   parameter int unsigned CREDIT_W    = 4,
   parameter int unsigned VAL1        = 1,
   parameter int unsigned VAL2        = 2,
   parameter int unsigned VAL3        = 5,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                ack,
   output logic                P,
   output logic                R,
   output logic [CREDIT_W-1:0] change,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam int unsigned SUM_W  = CREDIT_W + 1;
   localparam int unsigned MAX_12 = (VAL1 > VAL2) ? VAL1 : VAL2;
   localparam int unsigned MAX_V  = (MAX_12 > VAL3) ? MAX_12 : VAL3;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_VEND    = 2'd2;
   localparam logic [1:0] S_RETURN  = 2'd3;

   // Largest reachable sum must fit the credit/change datapath
   if (PRICE - 1 + MAX_V >= (2 ** CREDIT_W)) begin : g_width_check
      $error("vend_fsm_param: CREDIT_W too narrow for PRICE and coin values");
   end
   if (TIMEOUT_CYC == 0) begin : g_timeout_check
      $error("vend_fsm_param: TIMEOUT_CYC must be at least 1");
   end

   logic [1:0]          state, state_n;
   logic [CREDIT_W-1:0] credit_n, change_n;
   logic                p_n, r_n, busy_n;
   logic [SUM_W-1:0]    coin_val, sum;

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] tcnt, tcnt_n;
`endif

   always_comb begin
      coin_val = '0;
      case (coin)
         2'b01:   coin_val = SUM_W'(VAL1);
         2'b10:   coin_val = SUM_W'(VAL2);
         2'b11:   coin_val = SUM_W'(VAL3);
         default: coin_val = '0;
      endcase
      sum = {1'b0, credit} + coin_val;
   end

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_n  = state;
      credit_n = credit;
      change_n = change;
`ifdef VEND_TIMEOUT_EN
      tcnt_n   = '0;
`endif
      case (state)
         S_IDLE, S_COLLECT: begin
            if (sum >= SUM_W'(PRICE)) begin
               state_n  = S_VEND;
               change_n = CREDIT_W'(sum - SUM_W'(PRICE));
               credit_n = '0;
            end else if (cancel) begin
               if (sum != '0) begin
                  state_n  = S_RETURN;
                  change_n = CREDIT_W'(sum);
                  credit_n = '0;
               end
            end else if (sum != '0) begin
               state_n  = S_COLLECT;
               credit_n = CREDIT_W'(sum);
`ifdef VEND_TIMEOUT_EN
               if (state == S_COLLECT && coin == 2'b00) begin
                  if (tcnt == TO_W'(TIMEOUT_CYC - 1)) begin
                     state_n  = S_RETURN;
                     change_n = credit;
                     credit_n = '0;
                  end else begin
                     tcnt_n = tcnt + TO_W'(1);
                  end
               end
`endif
            end
         end
         S_VEND, S_RETURN: begin
            if (ack) begin
               state_n  = S_IDLE;
               change_n = '0;
            end
         end
         default: state_n = S_IDLE;
      endcase
      p_n    = (state_n == S_VEND);
      r_n    = (state_n == S_RETURN) || ((state_n == S_VEND) && (change_n != '0));
      busy_n = (state_n == S_VEND) || (state_n == S_RETURN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         credit <= '0;
         change <= '0;
         P      <= 1'b0;
         R      <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         credit <= credit_n;
         change <= change_n;
         P      <= p_n;
         R      <= r_n;
         busy   <= busy_n;
      end
   end

`ifdef VEND_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tcnt <= '0;
      else     tcnt <= tcnt_n;
   end
`endif

endmodule

// File: tb/tb_vend_fsm_param.sv
// Self-checking bench for vend_fsm_param: directed scenarios plus randomized run against a behavioural model.
module tb_vend_fsm_param;
   localparam int PRICE = 3;
   localparam int TO    = 4;

   logic       clk, rst, cancel, ack;
   logic [1:0] coin;
   logic       P, R, busy;
   logic [3:0] change, credit;
   logic [10:0] obs;
   int checks, failures;

   assign obs = {P, R, busy, credit, change};

   vend_fsm_param #(.PRICE(3), .CREDIT_W(4), .VAL1(1), .VAL2(2), .VAL3(5), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .ack(ack),
      .P(P), .R(R), .change(change), .credit(credit), .busy(busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input logic [1:0] c, input logic k, input logic a);
      coin = c; cancel = k; ack = a;
      @(posedge clk); #1;
   endtask

   task automatic expect_obs(input string name, input logic [10:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s {P,R,busy,credit,change} got=%b want=%b", name, obs, exp);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; coin = 2'b00; cancel = 1'b0; ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs !== 11'b0) begin failures++; $display("FAIL reset_hold got=%b want=%b", obs, 11'b0); end
      rst = 1'b0;
      cyc(2'b00, 1'b0, 1'b0);
      checks++;
      if (obs !== 11'b0) begin failures++; $display("FAIL reset_release got=%b want=%b", obs, 11'b0); end
   endtask

   task automatic test_vend_exact;
      cyc(2'b01, 1'b0, 1'b0);
      checks++;
      if (obs !== {3'b000, 4'd1, 4'd0}) begin failures++; $display("FAIL exact_collect got=%b", obs); end
      cyc(2'b10, 1'b0, 1'b0);
      checks++;
      if (obs !== {3'b101, 4'd0, 4'd0}) begin failures++; $display("FAIL exact_vend got=%b want=%b", obs, {3'b101, 8'd0}); end
      cyc(2'b00, 1'b0, 1'b0);
      cyc(2'b00, 1'b0, 1'b0);
      checks++;
      if (obs !== {3'b101, 4'd0, 4'd0}) begin failures++; $display("FAIL exact_hold got=%b", obs); end
      cyc(2'b00, 1'b0, 1'b1);
      checks++;
      if (obs !== 11'b0) begin failures++; $display("FAIL exact_ack got=%b want=0", obs); end
   endtask

   task automatic test_vend_change;
      cyc(2'b10, 1'b0, 1'b0);
      cyc(2'b10, 1'b0, 1'b0);
      checks++;
      if (obs !== {3'b111, 4'd0, 4'd1}) begin failures++; $display("FAIL change1_vend got=%b", obs); end
      cyc(2'b00, 1'b0, 1'b1);
      checks++;
      if (obs !== 11'b0) begin failures++; $display("FAIL change1_ack got=%b want=0", obs); end
      cyc(2'b11, 1'b0, 1'b1);
      checks++;
      if (obs !== {3'b111, 4'd0, 4'd2}) begin failures++; $display("FAIL coin3_vend got=%b", obs); end
      cyc(2'b11, 1'b1, 1'b0);
      checks++;
      if (obs !== {3'b111, 4'd0, 4'd2}) begin failures++; $display("FAIL vend_ignores_inputs got=%b", obs); end
      cyc(2'b00, 1'b0, 1'b1);
      checks++;
      if (obs !== 11'b0) begin failures++; $display("FAIL coin3_ack got=%b want=0", obs); end
   endtask

   task automatic test_cancel;
      cyc(2'b00, 1'b1, 1'b0);
      checks++;
      if (obs !== 11'b0) begin failures++; $display("FAIL cancel_empty got=%b want=0", obs); end
      cyc(2'b01, 1'b0, 1'b0);
      cyc(2'b00, 1'b1, 1'b0);
      checks++;
      if (obs !== {3'b011, 4'd0, 4'd1}) begin failures++; $display("FAIL cancel_return got=%b", obs); end
      cyc(2'b00, 1'b0, 1'b1);
      checks++;
      if (obs !== 11'b0) begin failures++; $display("FAIL cancel_ack got=%b want=0", obs); end
      cyc(2'b01, 1'b0, 1'b0);
      cyc(2'b10, 1'b1, 1'b0);
      checks++;
      if (obs !== {3'b101, 4'd0, 4'd0}) begin failures++; $display("FAIL cancel_ignored got=%b", obs); end
      cyc(2'b00, 1'b0, 1'b1);
   endtask

   task automatic test_reset_midvend;
      cyc(2'b11, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs !== 11'b0) begin failures++; $display("FAIL async_reset got=%b want=0", obs); end
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(2'b00, 1'b0, 1'b1);
      cyc(2'b00, 1'b0, 1'b0);
      checks++;
      if (obs !== 11'b0) begin failures++; $display("FAIL reset_no_refund got=%b want=0", obs); end
   endtask

   task automatic test_timeout;
      cyc(2'b01, 1'b0, 1'b0);
      repeat (TO) cyc(2'b00, 1'b0, 1'b0);
`ifdef VEND_TIMEOUT_EN
      checks++;
      if (obs !== {3'b011, 4'd0, 4'd1}) begin failures++; $display("FAIL timeout_return got=%b", obs); end
      cyc(2'b00, 1'b0, 1'b1);
`else
      checks++;
      if (obs !== {3'b000, 4'd1, 4'd0}) begin failures++; $display("FAIL no_timeout_collect got=%b", obs); end
      cyc(2'b00, 1'b1, 1'b0);
      cyc(2'b00, 1'b0, 1'b1);
`endif
      checks++;
      if (obs !== 11'b0) begin failures++; $display("FAIL timeout_cleanup got=%b want=0", obs); end
   endtask

   // Model: mode 0 = accepting coins, 1 = vending, 2 = refunding
   task automatic test_random;
      int m_mode, m_credit, m_change, m_idle, sum, v;
      logic [1:0] c;
      logic k, a;
      logic [10:0] exp;
      m_mode = 0; m_credit = 0; m_change = 0; m_idle = 0;
      for (int i = 0; i < 600; i++) begin
         c = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) c = 2'b00;
         k = ($urandom_range(0, 7) == 0);
         a = ($urandom_range(0, 2) == 0);
         if (m_mode != 0) begin
            if (a) begin m_mode = 0; m_change = 0; end
         end else begin
            v = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : (c == 2'b11) ? 5 : 0;
            sum = m_credit + v;
            if (sum >= PRICE) begin
               m_mode = 1; m_change = sum - PRICE; m_credit = 0; m_idle = 0;
            end else if (k) begin
               if (sum > 0) begin m_mode = 2; m_change = sum; m_credit = 0; end
               m_idle = 0;
            end else begin
`ifdef VEND_TIMEOUT_EN
               if (m_credit > 0 && v == 0) m_idle++;
               else m_idle = 0;
               if (m_idle == TO) begin
                  m_mode = 2; m_change = m_credit; m_credit = 0; m_idle = 0;
               end else m_credit = sum;
`else
               m_credit = sum;
`endif
            end
         end
         cyc(c, k, a);
         exp = {m_mode == 1, m_mode == 2 || (m_mode == 1 && m_change != 0), m_mode != 0,
                4'(m_credit), 4'(m_change)};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL random cycle=%0d got=%b want=%b", i, obs, exp);
         end
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      test_reset;
      test_vend_exact;
      test_vend_change;
      test_cancel;
      test_reset_midvend;
      test_timeout;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vend_fsm_param.md
VEND_FSM_PARAM -- requirements
Module: vend_fsm_param

Interface
REQ-001 SHALL have parameter PRICE, default 3, product price in Rs.
REQ-002 SHALL have parameter CREDIT_W, default 4, width of the credit and change datapath.
REQ-003 SHALL have parameter VAL1, default 1, value in Rs of coin code 2'b01.
REQ-004 SHALL have parameter VAL2, default 2, value in Rs of coin code 2'b10.
REQ-005 SHALL have parameter VAL3, default 5, value in Rs of coin code 2'b11.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 16, the idle-collect timeout in cycles; it is used only under VEND_TIMEOUT_EN.
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-009 SHALL have port coin, input, 2, one coin per cycle: 00 none, 01 VAL1, 10 VAL2, 11 VAL3.
REQ-010 SHALL have port cancel, input, 1, a refund request.
REQ-011 SHALL have port ack, input, 1, the customer/mechanism has taken the product and/or change.
REQ-012 SHALL have port P, output, 1, product dispense request.
REQ-013 SHALL have port R, output, 1, change/refund return request.
REQ-014 SHALL have port change, output, CREDIT_W, amount returned, meaningful while R=1.
REQ-015 SHALL have port credit, output, CREDIT_W, current accumulated credit.
REQ-016 SHALL have port busy, output, 1, high in VEND or RETURN; coins are not accepted.

Function
REQ-017 SHALL implement the states IDLE (credit=0), COLLECT, VEND and RETURN, with all outputs decoded from registered state only (Moore).
REQ-018 SHALL, in IDLE/COLLECT, form sum = credit + coin value each cycle; coin 00 contributes 0.
REQ-019 SHALL, when sum >= PRICE, go to VEND on the next edge with change = sum - PRICE and credit cleared to 0; cancel in the same cycle is ignored.
REQ-020 SHALL, when 0 < sum < PRICE and cancel=0, go to or stay in COLLECT with credit = sum.
REQ-021 SHALL, when cancel=1 and sum < PRICE, go to RETURN with change = sum if sum > 0; cancel with sum = 0 stays in IDLE with no effect.
REQ-022 SHALL, in VEND, drive P=1 and R=(change!=0), holding both until ack=1, then go to IDLE on that edge with change cleared.
REQ-023 SHALL, in RETURN, drive P=0, R=1 and change = refunded amount until ack=1, then go to IDLE.
REQ-024 SHALL, in VEND/RETURN, ignore coin and cancel, leaving credit and change unchanged; ack in IDLE/COLLECT is ignored.
REQ-025 SHALL produce 1-cycle latency from the coin-accept edge to P/R assertion, with a minimum of one cycle in VEND/RETURN even if ack is already high.
REQ-026 SHALL perform arithmetic at CREDIT_W+1 bits internally, and SHALL fail elaboration (static check) if PRICE-1+max(VAL1,VAL2,VAL3) >= 2**CREDIT_W.
REQ-027 SHALL hold P=R=0 and change=0 in IDLE and COLLECT.

Reset
REQ-028 SHALL, on rst=1, immediately and asynchronously go to IDLE with credit=0, change=0, P=0, R=0, busy=0 and the timeout counter at 0.
REQ-029 SHALL forfeit any credit held when reset is asserted mid-transaction, including in VEND or RETURN, with no refund issued after reset release.

Configuration
REQ-030 SHALL, with VEND_TIMEOUT_EN defined, count consecutive COLLECT cycles with coin=00 and cancel=0; on reaching TIMEOUT_CYC it goes to RETURN with change=credit, and any coin or state exit clears the counter.
REQ-031 SHALL, with VEND_TIMEOUT_EN undefined, contain no counter logic, remain in COLLECT indefinitely, and leave TIMEOUT_CYC unused.

Verification
REQ-032 SHALL cover: PRICE=3, coins 01,10, ack after 2 cycles -> VEND with P=1, R=0, change=0, then IDLE after ack.
REQ-033 SHALL cover: coins 10,10 -> VEND with P=1, R=1, change=1; ack -> IDLE with credit=0.
REQ-034 SHALL cover: coin 11 from IDLE -> VEND with change=2 in one step.
REQ-035 SHALL cover: coin 01 then cancel -> RETURN with R=1, change=1, P=0; coin 10 plus cancel at credit=1 -> VEND with change=0, cancel ignored.
REQ-036 SHALL cover: rst pulse while in VEND with change=2 -> outputs 0 immediately, IDLE after release, no P/R.
REQ-037 SHALL cover: with VEND_TIMEOUT_EN and TIMEOUT_CYC=4, coin 01 then 4 idle cycles -> RETURN with change=1; without the macro -> stays in COLLECT with credit=1.
